// File: rtl/sd_cmd_sequencer.sv
// SD SPI command-frame sequencer: latches cmd/arg, obtains CRC7 from the shared engine and
// streams the 6-byte frame over valid/ready. Define SD_CMD_SEQ_R1_EN to add R1 polling.
module sd_cmd_sequencer #(
  parameter int unsigned CRC_TIMEOUT = 255,
  parameter int unsigned NCR_MAX     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  cmd_idx,
  input  logic [31:0] cmd_arg,
  input  logic        go,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [6:0]  crc_out,
  output logic [7:0]  r1,
  output logic [39:0] crc_data,
  output logic        crc_start,
  input  logic [6:0]  crc_result,
  input  logic        crc_done,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid
);

`ifdef SD_CMD_SEQ_R1_EN
  localparam int unsigned FillW = $clog2(NCR_MAX + 1);
  localparam logic [FillW-1:0] FillLast = FillW'(NCR_MAX);

  typedef enum logic [2:0] {StIdle, StCrcStart, StCrcWait, StSend, StResp, StFinish} state_e;

  logic [FillW-1:0] fill_q, fill_d;
`else
  typedef enum logic [2:0] {StIdle, StCrcStart, StCrcWait, StSend, StFinish} state_e;

  logic unused_rx;
  assign unused_rx = ^{rx_byte, rx_valid, NCR_MAX[0]};
`endif

  // Counter saturates one below the limit so the abort lands exactly CRC_TIMEOUT waits in.
  localparam logic [7:0] TmoLast = 8'(CRC_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [2:0]  idx_q, idx_d;
  logic [39:0] crc_data_d;
  logic [6:0]  crc_out_d;
  logic [7:0]  r1_d;
  logic        err_d;
  logic [7:0]  send_byte;

  always_comb begin
    case (idx_q)
      3'd0:    send_byte = crc_data[39:32];
      3'd1:    send_byte = crc_data[31:24];
      3'd2:    send_byte = crc_data[23:16];
      3'd3:    send_byte = crc_data[15:8];
      3'd4:    send_byte = crc_data[7:0];
      3'd5:    send_byte = {crc_out, 1'b1};
      default: send_byte = 8'hFF;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    idx_d      = idx_q;
    crc_data_d = crc_data;
    crc_out_d  = crc_out;
    r1_d       = r1;
    err_d      = err;
`ifdef SD_CMD_SEQ_R1_EN
    fill_d     = fill_q;
`endif
    busy       = (state_q != StIdle);
    done       = 1'b0;
    crc_start  = 1'b0;
    tx_valid   = 1'b0;
    tx_byte    = 8'hFF;

    case (state_q)
      StIdle: begin
        if (go) begin
          crc_data_d = {2'b01, cmd_idx, cmd_arg};
          err_d      = 1'b0;
          r1_d       = 8'hFF;
          state_d    = StCrcStart;
        end
      end
      StCrcStart: begin
        crc_start = 1'b1;
        tmo_d     = 8'd0;
        state_d   = StCrcWait;
      end
      StCrcWait: begin
        // A completion on the final wait cycle still wins over the timeout.
        if (crc_done) begin
          crc_out_d = crc_result;
          idx_d     = 3'd0;
          state_d   = StSend;
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StFinish;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StSend: begin
        tx_valid = 1'b1;
        tx_byte  = send_byte;
        if (tx_ready) begin
          if (idx_q == 3'd5) begin
`ifdef SD_CMD_SEQ_R1_EN
            fill_d  = '0;
            state_d = StResp;
`else
            state_d = StFinish;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef SD_CMD_SEQ_R1_EN
      StResp: begin
        tx_valid = (fill_q != FillLast);
        if (rx_valid && !rx_byte[7]) begin
          r1_d    = rx_byte;
          state_d = StFinish;
        end else if (rx_valid && fill_q == FillLast) begin
          r1_d    = 8'hFF;
          err_d   = 1'b1;
          state_d = StFinish;
        end else if (tx_valid && tx_ready) begin
          fill_d = fill_q + 1'b1;
        end
      end
`endif
      StFinish: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      tmo_q    <= 8'd0;
      idx_q    <= 3'd0;
      crc_data <= 40'd0;
      crc_out  <= 7'd0;
      r1       <= 8'hFF;
      err      <= 1'b0;
`ifdef SD_CMD_SEQ_R1_EN
      fill_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      idx_q    <= idx_d;
      crc_data <= crc_data_d;
      crc_out  <= crc_out_d;
      r1       <= r1_d;
      err      <= err_d;
`ifdef SD_CMD_SEQ_R1_EN
      fill_q   <= fill_d;
`endif
    end
  end

endmodule

// File: doc/sd_cmd_sequencer.md
# sd_cmd_sequencer

Sequencer that builds and issues SD-card SPI command frames. It captures a command index and 32-bit argument and runs the shared CRC7 engine over the 40-bit header. It then streams the 6-byte frame to the SPI byte transmitter over a valid/ready handshake and, optionally, polls for the R1 response. It sits between the CPU-side SD peripheral registers and the CRC7 engine / SPI shifter in the SPI_SD subsystem.

## Interface
- CRC_TIMEOUT, 255: max cycles in CRC_WAIT before abort (8-bit counter).
- NCR_MAX, 8: max 0xFF fill bytes sent while polling for R1.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active high.
- cmd_idx  in  6  SD command index.
- cmd_arg  in  32  command argument.
- go  in  1  start request; accepted only in IDLE.
- busy  out  1  high from cycle after accepted go until done pulse.
- done  out  1  one-cycle completion pulse.
- err  out  1  set on CRC timeout or R1 timeout; cleared on next accepted go.
- crc_out  out  7  CRC7 latched from engine.
- r1  out  8  captured R1 byte; 0xFF if none.
- crc_data  out  40  {2'b01, cmd_idx, cmd_arg} held stable from CRC_START through CRC_WAIT.
- crc_start  out  1  one-cycle pulse to engine.
- crc_result  in  7  engine result, valid with crc_done.
- crc_done  in  1  engine completion.
- tx_byte  out  8  byte to SPI transmitter.
- tx_valid  out  1  tx_byte valid.
- tx_ready  in  1  transmitter accepts when tx_valid && tx_ready.
- rx_byte  in  8  byte received by SPI shifter.
- rx_valid  in  1  rx_byte valid, one-cycle pulse.

## Operation
- Reset values: busy=0, done=0, err=0, crc_out=0, r1=8'hFF, crc_data=0, crc_start=0, tx_byte=8'hFF, tx_valid=0; state IDLE.
- IDLE: on go, latch cmd_idx/cmd_arg, clear err, go to CRC_START. Later input changes have no effect.
- CRC_START: crc_start=1 for one cycle, clear timeout counter, go to CRC_WAIT.
- CRC_WAIT: on crc_done latch crc_out=crc_result, go to SEND. Counter increments each cycle. On reaching CRC_TIMEOUT, set err, go to FINISH, and send no bytes. crc_done on the same cycle as timeout: done wins. crc_done outside CRC_WAIT is ignored.
- SEND: byte index 0..5 sends {2'b01,cmd_idx}, arg[31:24], arg[23:16], arg[15:8], arg[7:0], {crc_out,1'b1}, MSB byte first. tx_byte/tx_valid hold until handshake. The index advances on handshake. After byte 5 the state goes to RESP (macro on) or FINISH.
- RESP (macro on): send 8'hFF fill bytes via the same handshake.
  - On rx_valid with rx_byte[7]==0: capture r1 and go to FINISH.
  - After NCR_MAX fill handshakes with no valid R1 and a final rx_valid not matching: r1=8'hFF, err=1, FINISH.
- FINISH: done=1 for one cycle, busy=0 the next cycle, then IDLE.
- go while busy is ignored and not queued.
- rst asserted mid-operation: all outputs return to reset values at that edge and tx_valid drops. The partially sent frame is abandoned.

## Timing
- go sampled high in cycle N (IDLE) → busy=1 and crc_start=1 in cycle N+1; crc_done is sampled from N+2.
- crc_done in cycle M → tx_valid=1 with byte 0 in cycle M+1.
- Handshake in cycle K → next byte presented in K+1; throughput is 1 byte/cycle with tx_ready tied high.
- Minimum frame with macro off and a zero-latency engine (crc_done at N+2): last handshake at N+8, done at N+9, busy low at N+10.
- CRC timeout: err and done assert CRC_TIMEOUT+2 cycles after go acceptance; tx_valid never rises.

## Configuration
- SD_CMD_SEQ_R1_EN defined: RESP state, fill-byte polling and r1 capture are compiled in.
- Not defined: RESP state is absent. FINISH follows byte 5's handshake, r1 stays 8'hFF, rx_byte/rx_valid are unused, and err only signals CRC timeout.

## Test plan
- CMD0, arg 0, engine returns 7'h4A → tx bytes 40 00 00 00 00 95; crc_data=40'h4000000000; done once; err=0.
- CMD8, arg 32'h000001AA, engine returns 7'h43 → bytes 48 00 00 01 AA 87. tx_ready low 3 cycles on byte 2 → tx_byte holds 8'h00, no duplication.
- crc_done never asserted → err=1, done pulse CRC_TIMEOUT+2 cycles after go, zero tx handshakes.
- Macro on: rx_byte FF, FF, then 01 → three fill bytes sent, r1=8'h01, err=0. All rx_byte FF → NCR_MAX fills, r1=8'hFF, err=1.
- go pulsed during SEND → ignored, single frame. rst during byte 3 → tx_valid=0 and busy=0 next cycle; a new go sends a full correct frame.
